// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the registered decode stage.
//   opcode_e    - 3-bit major opcode
//   ALU_*       - ALU operation codes (4-bit native, zero-extended at the top)
//   ctrl_word_t - decoded control word; address and op fields are 4 bits wide
//                 because every decoded value fits in 4 bits, and the top
//                 zero-extends them to RADDR_W / ALUOP_W
//   state_e     - issue FSM states
package decode_pkg;

  localparam int FIELD_W = 4;

  typedef enum logic [2:0] {
    OP_R   = 3'd0,
    OP_LD  = 3'd1,
    OP_ST  = 3'd2,
    OP_IMM = 3'd3,
    OP_BR  = 3'd4,
    OP_MOV = 3'd5,
    OP_SH  = 3'd6,
    OP_LOG = 3'd7
  } opcode_e;

  localparam logic [FIELD_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [FIELD_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [FIELD_W-1:0] ALU_LSL  = 4'd2;
  localparam logic [FIELD_W-1:0] ALU_ASR  = 4'd3;
  localparam logic [FIELD_W-1:0] ALU_LSR  = 4'd4;
  localparam logic [FIELD_W-1:0] ALU_NOT  = 4'd5;
  localparam logic [FIELD_W-1:0] ALU_AND  = 4'd6;
  localparam logic [FIELD_W-1:0] ALU_OR   = 4'd7;
  localparam logic [FIELD_W-1:0] ALU_MUL  = 4'd8;
  localparam logic [FIELD_W-1:0] ALU_PASS = 4'd15;

  typedef struct packed {
    logic               branch;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mov;
    logic               illegal;
    logic [FIELD_W-1:0] alu_op;
    logic [FIELD_W-1:0] reg_a;
    logic [FIELD_W-1:0] reg_b;
    logic [FIELD_W-1:0] wr_addr;
  } ctrl_word_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational instruction decoder.
//   instr  in  MCODE_W : machine code (opcode in top 3 bits, funct next 2)
//   cw     out         : decoded control word
//   is_mul out 1       : instruction is a MUL (needs multi-cycle issue)
module decode_comb
  import decode_pkg::*;
#(
  parameter int MCODE_W = 9
) (
  input  logic [MCODE_W-1:0] instr,
  output ctrl_word_t         cw,
  output logic               is_mul
);

  opcode_e    op;
  logic [1:0] funct;

  assign op    = opcode_e'(instr[MCODE_W-1 -: 3]);
  assign funct = instr[MCODE_W-4 -: 2];

  always_comb begin
    cw           = '0;
    cw.reg_write = 1'b1;
    cw.alu_op    = ALU_PASS;
    cw.wr_addr   = instr[3:0];
    is_mul       = 1'b0;
    case (op)
      OP_R: begin
        cw.reg_b = 4'd1;
        case (funct)
          2'd0: cw.alu_op = ALU_ADD;
          2'd1: cw.alu_op = ALU_SUB;
          2'd2: cw.mem_to_reg = 1'b1;
          default: begin
            cw.reg_write = 1'b0;
            cw.mem_write = 1'b1;
          end
        endcase
      end
      OP_LD:  cw.mem_to_reg = 1'b1;
      OP_ST: begin
        cw.reg_write = 1'b0;
        cw.mem_write = 1'b1;
      end
      OP_IMM: cw.alu_src = 1'b1;
      OP_BR: begin
        cw.branch    = 1'b1;
        cw.reg_write = 1'b0;
      end
      OP_MOV: begin
        cw.mov     = 1'b1;
        cw.reg_a   = instr[4:1];
        cw.wr_addr = {3'b000, instr[5]};
      end
      OP_SH: begin
        cw.reg_b = 4'd1;
        case (funct)
          2'd0:    cw.alu_op = ALU_LSL;
          2'd1:    cw.alu_op = ALU_ASR;
          2'd2:    cw.alu_op = ALU_LSR;
          default: cw.alu_op = ALU_NOT;
        endcase
      end
      default: begin // OP_LOG
        cw.reg_b = 4'd1;
        case (funct)
          2'd0: cw.alu_op = ALU_AND;
          2'd1: cw.alu_op = ALU_OR;
          2'd2: begin
            cw.alu_op = ALU_MUL;
            is_mul    = 1'b1;
          end
          default: begin
            // funct 11 is unassigned: squash every side effect
            cw.illegal   = 1'b1;
            cw.reg_write = 1'b0;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with valid/ready handshakes.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : instruction handshake (instr)
//   flush                 : taken branch; drops held/pending instruction
//   out_valid/out_ready   : control-word handshake to execute
//   branch..illegal       : control flags
//   alu_op, reg_a/b, wr_addr : decoded fields
//   illegal_cnt           : saturating count of accepted illegal words
// MUL is held in MUL_WAIT for MUL_CYCLES-1 cycles before out_valid rises.
module decode_stage
  import decode_pkg::*;
#(
  parameter int MCODE_W    = 9,
  parameter int RADDR_W    = 4,
  parameter int ALUOP_W    = 4,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MCODE_W-1:0] instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               branch,
  output logic               mem_write,
  output logic               alu_src,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               mov,
  output logic               illegal,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [RADDR_W-1:0] reg_a,
  output logic [RADDR_W-1:0] reg_b,
  output logic [RADDR_W-1:0] wr_addr,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e     state, state_nxt;
  logic [CW-1:0] cnt;
  ctrl_word_t dec, cw_q;
  logic       dec_mul, accept, mul_start, mul_done;

  decode_comb #(.MCODE_W(MCODE_W)) u_comb (
    .instr  (instr),
    .cw     (dec),
    .is_mul (dec_mul)
  );

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && dec_mul && (MUL_CYCLES > 1);
  // cnt==1 now means it reaches 0 at this edge
  assign mul_done  = (state == MUL_WAIT) && (cnt == CW'(1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (mul_start) state_nxt = MUL_WAIT;
        default:  if (mul_done)  state_nxt = IDLE;
      endcase
    end
  end

  // outputs of the FSM
  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  end

  // output register, MUL countdown and illegal counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      cnt         <= '0;
      cw_q        <= '0;
      cw_q.alu_op <= ALU_PASS;
      illegal_cnt <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        cnt       <= '0;
      end else if (state == MUL_WAIT) begin
        cnt <= cnt - 1'b1;
        if (mul_done) out_valid <= 1'b1;
      end else if (accept) begin
        cw_q      <= dec;
        out_valid <= !mul_start;
        if (mul_start) cnt <= CW'(MUL_CYCLES - 1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // accept never coincides with flush, so a later flush cannot undo this
      if (accept && dec.illegal && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign branch     = cw_q.branch;
  assign mem_write  = cw_q.mem_write;
  assign alu_src    = cw_q.alu_src;
  assign reg_write  = cw_q.reg_write;
  assign mem_to_reg = cw_q.mem_to_reg;
  assign mov        = cw_q.mov;
  assign illegal    = cw_q.illegal;
  assign alu_op     = ALUOP_W'(cw_q.alu_op);
  assign reg_a      = RADDR_W'(cw_q.reg_a);
  assign reg_b      = RADDR_W'(cw_q.reg_b);
  assign wr_addr    = RADDR_W'(cw_q.wr_addr);

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scenario tasks plus a scoreboard monitor for decode_stage.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, flush, out_valid, out_ready;
  logic [8:0] instr;
  logic       branch, mem_write, alu_src, reg_write, mem_to_reg, mov, illegal;
  logic [3:0] alu_op, reg_a, reg_b, wr_addr;
  logic [1:0] illegal_cnt;

  int checks = 0;
  int errors = 0;

  logic [22:0] q[$];
  logic [22:0] obs;

  always #5 clk = ~clk;

  decode_stage #(.MCODE_W(9), .RADDR_W(4), .ALUOP_W(4), .MUL_CYCLES(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .branch(branch), .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mov(mov), .illegal(illegal), .alu_op(alu_op),
    .reg_a(reg_a), .reg_b(reg_b), .wr_addr(wr_addr), .illegal_cnt(illegal_cnt)
  );

  assign obs = {branch, mem_write, alu_src, reg_write, mem_to_reg, mov, illegal,
                alu_op, reg_a, reg_b, wr_addr};

  // reference decode: {br,mw,as,rw,mr,mv,il,alu_op,reg_a,reg_b,wr_addr}
  function automatic logic [22:0] model(input logic [8:0] i);
    logic br, mw, as_, rw, mr, mv, il;
    logic [3:0] op, ra, rb, wa;
    br = 0; mw = 0; as_ = 0; rw = 1; mr = 0; mv = 0; il = 0;
    op = 4'd15; ra = 4'd0; rb = 4'd0; wa = i[3:0];
    case (i[8:6])
      3'd0: begin
        rb = 4'd1;
        case (i[5:4])
          2'd0: op = 4'd0;
          2'd1: op = 4'd1;
          2'd2: mr = 1;
          default: begin rw = 0; mw = 1; end
        endcase
      end
      3'd1: mr = 1;
      3'd2: begin rw = 0; mw = 1; end
      3'd3: as_ = 1;
      3'd4: begin br = 1; rw = 0; end
      3'd5: begin mv = 1; ra = i[4:1]; wa = {3'b0, i[5]}; end
      3'd6: begin rb = 4'd1; op = 4'd2 + {2'b0, i[5:4]}; end
      default: begin
        rb = 4'd1;
        case (i[5:4])
          2'd0: op = 4'd6;
          2'd1: op = 4'd7;
          2'd2: op = 4'd8;
          default: begin il = 1; rw = 0; end
        endcase
      end
    endcase
    return {br, mw, as_, rw, mr, mv, il, op, ra, rb, wa};
  endfunction

  // scoreboard: push on accept, pop/compare on output handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got word %h, required none pending", obs);
        end else begin
          logic [22:0] e;
          e = q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL sb_word: got %h, required %h", obs, e);
          end
        end
      end
      if (flush) q.delete();
      if (in_valid && in_ready) q.push_back(model(instr));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; flush = 0; instr = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    checks++; if (alu_op !== 4'd15) begin errors++; $display("FAIL rst_alu_op: got %0d, required 15", alu_op); end
    checks++; if (illegal_cnt !== 2'd0) begin errors++; $display("FAIL rst_illegal_cnt: got %0d, required 0", illegal_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rst_reg_write: got %b, required 0", reg_write); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1; in_valid = 1; instr = 9'b000_00_0011;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b, required 1", in_ready); end
    tick();
    instr = 9'b110_01_0101;
    #1;
    checks++; if (out_valid !== 1'b1 || alu_op !== 4'd0 || wr_addr !== 4'd3)
      begin errors++; $display("FAIL b2b_first: got v=%b op=%0d wa=%0d, required v=1 op=0 wa=3", out_valid, alu_op, wr_addr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b, required 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || alu_op !== 4'd3 || wr_addr !== 4'd5)
      begin errors++; $display("FAIL b2b_second: got v=%b op=%0d wa=%0d, required v=1 op=3 wa=5", out_valid, alu_op, wr_addr); end
    in_valid = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b, required 0", out_valid); end
  endtask

  task automatic test_mul();
    out_ready = 1; in_valid = 1; instr = 9'b111_10_0010;
    tick();
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
        begin errors++; $display("FAIL mul_wait%0d: got v=%b rdy=%b, required v=0 rdy=0", k, out_valid, in_ready); end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || alu_op !== 4'd8)
      begin errors++; $display("FAIL mul_done: got v=%b op=%0d, required v=1 op=8", out_valid, alu_op); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; instr = 9'b101_1_1010_0;
    tick();
    instr = 9'b000_00_0001;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || mov !== 1'b1 || reg_a !== 4'b1010 || wr_addr !== 4'd1 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d: got v=%b mov=%b ra=%h wa=%0d rdy=%b, required 1 1 a 1 0",
                                 k, out_valid, mov, reg_a, wr_addr, in_ready); end
      tick();
    end
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b1 || alu_op !== 4'd0 || wr_addr !== 4'd1)
      begin errors++; $display("FAIL bp_next: got v=%b op=%0d wa=%0d, required v=1 op=0 wa=1", out_valid, alu_op, wr_addr); end
    in_valid = 0;
    tick();
  endtask

  task automatic test_flush();
    // flush one cycle into a MUL
    out_ready = 1; in_valid = 1; instr = 9'b111_10_0001;
    tick();
    in_valid = 0; flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ready: got %b, required 0", in_ready); end
    tick();
    flush = 0; in_valid = 1; instr = 9'b011_00_0111;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL fl_after: got v=%b rdy=%b, required v=0 rdy=1", out_valid, in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || alu_src !== 1'b1 || wr_addr !== 4'd7)
      begin errors++; $display("FAIL fl_next: got v=%b as=%b wa=%0d, required 1 1 7", out_valid, alu_src, wr_addr); end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_mul%0d: got %b, required 0", k, out_valid); end
      tick();
    end
    // flush while a word is stalled: word dropped
    out_ready = 0; in_valid = 1; instr = 9'b001_00_0100;
    tick();
    in_valid = 0; flush = 1;
    tick();
    flush = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_held: got %b, required 0", out_valid); end
    // flush with out_ready: word consumed, out_valid still drops
    in_valid = 1; instr = 9'b100_00_0010;
    tick();
    in_valid = 0; flush = 1; out_ready = 1;
    tick();
    flush = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_consume: got %b, required 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1; in_valid = 1; instr = 9'b111_10_0110;
    tick();
    in_valid = 0; rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL rmm_reset: got v=%b rdy=%b, required v=0 rdy=1", out_valid, in_ready); end
    tick();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin errors++; $display("FAIL rmm_idle%0d: got v=%b rdy=%b, required v=0 rdy=1", k, out_valid, in_ready); end
    end
  endtask

  task automatic test_illegal();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    out_ready = 1; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      instr = {5'b111_11, 4'(k * 3)};
      tick();
      checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || reg_write !== 1'b0 || illegal_cnt !== exp_cnt[k])
        begin errors++; $display("FAIL ill_%0d: got v=%b il=%b rw=%b cnt=%0d, required 1 1 0 %0d",
                                 k, out_valid, illegal, reg_write, illegal_cnt, exp_cnt[k]); end
    end
    in_valid = 0; flush = 1;
    tick();
    flush = 0;
    checks++; if (illegal_cnt !== 2'd3) begin errors++; $display("FAIL ill_flush: got %0d, required 3", illegal_cnt); end
  endtask

  task automatic test_all_opcodes();
    for (int k = 0; k < 32; k++) begin
      int guard;
      in_valid = 1;
      instr = {5'(k), 4'($urandom_range(0, 15))};
      out_ready = 1'($urandom_range(0, 1));
      #1;
      guard = 0;
      while (!in_ready && guard < 20) begin
        tick();
        out_ready = 1'($urandom_range(0, 1));
        #1;
        guard++;
      end
      if (guard >= 20) begin
        checks++; errors++;
        $display("FAIL op_accept_timeout: word %0d got no in_ready, required accept", k);
      end
      tick();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 20 && (q.size() != 0 || out_valid); k++) tick();
    checks++; if (q.size() != 0) begin errors++; $display("FAIL op_drain: got %0d pending, required 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    test_illegal();
    test_all_opcodes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
